// File: rtl/tlp_reassembly_pkg.sv
// Shared constants, FSM encoding and header bit positions
// for the RX TLP reassembly path.
package rx_frag_package;

  localparam int DW          = 32;
  localparam int BEAT_DW     = 8;
  localparam int MAX_DATA_DW = 32;
  localparam int HDR_MAX_DW  = 4;
  localparam int MAX_TLP_DW  = HDR_MAX_DW + MAX_DATA_DW;
  localparam int PTR_WIDTH   = 6;

  localparam int FMT_4DW_BIT  = 29;
  localparam int FMT_DATA_BIT = 30;
  localparam int LEN_MSB      = 9;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DROP,
    HOLD
  } state_e;

endpackage

// File: rtl/tlp_reassembly_hdr_check.sv
// Header decode and length check for a fully received TLP.
// In: DW0, total DWs, eop dw count. Out: hdr4, hlen, payload len, err.
module tlp_hdr_check
  import rx_frag_package::*;
(
  input  logic [DW-1:0]        dw0_i,
  input  logic [PTR_WIDTH:0]   total_i,
  input  logic [3:0]           dw_cnt_i,
  output logic                 hdr4_o,
  output logic [2:0]           hlen_o,
  output logic [PTR_WIDTH-1:0] plen_o,
  output logic                 err_o
);

  logic               has_data;
  logic [LEN_MSB:0]   len;
  logic [PTR_WIDTH:0] rx;
  logic               short_pkt;
  logic               unused_bits;

  assign unused_bits = ^{dw0_i[DW-1],
                         dw0_i[FMT_4DW_BIT-1:LEN_MSB+1]};

  always_comb begin
    hdr4_o    = dw0_i[FMT_4DW_BIT];
    has_data  = dw0_i[FMT_DATA_BIT];
    len       = dw0_i[LEN_MSB:0];
    hlen_o    = hdr4_o ? 3'd4 : 3'd3;
    short_pkt = total_i < {4'b0, hlen_o};
    rx        = total_i - {4'b0, hlen_o};
    err_o     = short_pkt
             || dw_cnt_i == 4'd0
             || dw_cnt_i > 4'd8;
    if (has_data) begin
      err_o = err_o
           || len == 10'd0
           || len > 10'd32
           || len != {3'b0, rx};
    end else begin
      err_o = err_o || rx != 7'd0;
    end
    plen_o = has_data ? len[PTR_WIDTH-1:0] : '0;
  end

endmodule

// File: rtl/tlp_reassembly.sv
// Collects 8-DW beats into one TLP, checks its length and
// presents header + payload on a wide valid/ready output.
// In: in_* beat stream, out_ready. Out: in_ready, out_*, err_pulse.
module tlp_reassembly
  import rx_frag_package::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BEAT_DW*DW-1:0]     in_data,
  input  logic                      in_valid,
  input  logic                      in_sop,
  input  logic                      in_eop,
  input  logic [3:0]                in_dw_cnt,
  output logic                      in_ready,
  output logic [HDR_MAX_DW*DW-1:0]  out_hdr,
  output logic                      out_hdr_4dw,
  output logic [MAX_DATA_DW*DW-1:0] out_data,
  output logic [PTR_WIDTH-1:0]      out_data_len,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      err_pulse
);

  state_e                    state_q;
  logic [PTR_WIDTH-1:0]      ptr_q;
  logic [DW-1:0]             asm_q [MAX_TLP_DW];
  logic [DW-1:0]             asm_d [MAX_TLP_DW];
  logic                      in_ready_q;
  logic                      out_valid_q;
  logic                      err_q;
  logic                      hdr4_q;
  logic [HDR_MAX_DW*DW-1:0]  hdr_q;
  logic [MAX_DATA_DW*DW-1:0] data_q;
  logic [PTR_WIDTH-1:0]      len_q;

  logic                      acc;
  logic                      restart;
  logic                      writing;
  logic [PTR_WIDTH-1:0]      base;
  logic [3:0]                cnt;
  logic [PTR_WIDTH:0]        sum;
  logic                      ovf;
  logic [PTR_WIDTH-1:0]      idx;
  logic [PTR_WIDTH-1:0]      src;

  logic                      chk_hdr4;
  logic [2:0]                chk_hlen;
  logic [PTR_WIDTH-1:0]      chk_plen;
  logic                      chk_err;
  logic [HDR_MAX_DW*DW-1:0]  hdr_d;
  logic [MAX_DATA_DW*DW-1:0] data_d;

  // Beat merge: the incoming beat overlays the assembly
  // buffer at the write pointer; a sop restarts at 0.
  always_comb begin
    acc     = in_valid && in_ready_q;
    restart = in_sop && state_q != HOLD;
    writing = acc && (restart || state_q == COLLECT);
    base    = restart ? '0 : ptr_q;
    cnt     = in_eop ? in_dw_cnt : 4'd8;
    // 7-bit sum so the >36 compare never sees a wrap
    sum     = {1'b0, base} + {3'b0, cnt};
    ovf     = sum > 7'(MAX_TLP_DW);
    asm_d   = asm_q;
    idx     = '0;
    for (int i = 0; i < BEAT_DW; i++) begin
      idx = base + 6'(i);
      if (idx < 6'(MAX_TLP_DW)) begin
        asm_d[idx] = in_data[(BEAT_DW-1-i)*DW +: DW];
      end
    end
  end

  tlp_hdr_check u_chk (
    .dw0_i    (asm_d[0]),
    .total_i  (sum),
    .dw_cnt_i (in_dw_cnt),
    .hdr4_o   (chk_hdr4),
    .hlen_o   (chk_hlen),
    .plen_o   (chk_plen),
    .err_o    (chk_err)
  );

  // Payload starts right after the header and is packed
  // to the top of out_data; DW3 is header only for 4DW.
  always_comb begin
    hdr_d  = {asm_d[0], asm_d[1], asm_d[2],
              chk_hdr4 ? asm_d[3] : '0};
    data_d = '0;
    src    = '0;
    for (int k = 0; k < MAX_DATA_DW; k++) begin
      src = {3'b0, chk_hlen} + 6'(k);
      if (6'(k) < chk_plen) begin
        data_d[(MAX_DATA_DW-1-k)*DW +: DW] = asm_d[src];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      asm_q       <= '{default: '0};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      hdr4_q      <= 1'b0;
      hdr_q       <= '0;
      data_q      <= '0;
      len_q       <= '0;
    end else begin
      err_q <= 1'b0;
      if (state_q == HOLD) begin
        if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          ptr_q       <= '0;
          state_q     <= IDLE;
        end
      end else if (writing) begin
        asm_q <= asm_d;
        // sop inside COLLECT abandons the old TLP
        if (restart && state_q == COLLECT) begin
          err_q <= 1'b1;
        end
        if (ovf) begin
          err_q   <= 1'b1;
          ptr_q   <= '0;
          state_q <= in_eop ? IDLE : DROP;
        end else if (!in_eop) begin
          ptr_q   <= sum[PTR_WIDTH-1:0];
          state_q <= COLLECT;
        end else if (chk_err) begin
          err_q   <= 1'b1;
          ptr_q   <= '0;
          state_q <= IDLE;
        end else begin
          ptr_q       <= sum[PTR_WIDTH-1:0];
          hdr_q       <= hdr_d;
          hdr4_q      <= chk_hdr4;
          data_q      <= data_d;
          len_q       <= chk_plen;
          out_valid_q <= 1'b1;
          in_ready_q  <= 1'b0;
          state_q     <= HOLD;
        end
      end else if (acc && state_q == DROP && in_eop) begin
        ptr_q   <= '0;
        state_q <= IDLE;
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign err_pulse    = err_q;
  assign out_hdr      = hdr_q;
  assign out_hdr_4dw  = hdr4_q;
  assign out_data     = data_q;
  assign out_data_len = len_q;

endmodule

// File: tb/tb_tlp_reassembly.sv
// Randomized scoreboard bench for tlp_reassembly.
// Driver predicts events; a negedge monitor checks them.
module tb_tlp_reassembly;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [255:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_sop = 1'b0;
  logic           in_eop = 1'b0;
  logic [3:0]     in_dw_cnt = '0;
  logic           in_ready;
  logic [127:0]   out_hdr;
  logic           out_hdr_4dw;
  logic [1023:0]  out_data;
  logic [5:0]     out_data_len;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           err_pulse;

  always #5 clk = ~clk;

  tlp_reassembly dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_sop       (in_sop),
    .in_eop       (in_eop),
    .in_dw_cnt    (in_dw_cnt),
    .in_ready     (in_ready),
    .out_hdr      (out_hdr),
    .out_hdr_4dw  (out_hdr_4dw),
    .out_data     (out_data),
    .out_data_len (out_data_len),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .err_pulse    (err_pulse)
  );

  typedef struct {
    bit            is_err;
    int            cyc;
    logic [127:0]  hdr;
    bit            hdr4;
    logic [1023:0] data;
    logic [5:0]    len;
  } exp_t;

  exp_t q[$];
  exp_t me;
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   stall = 1'b0;
  bit   abandon = 1'b0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = stall ? 1'b0 : ($urandom_range(0, 9) < 7);
  end

  task automatic chk(input string nm,
                     input logic [63:0] a,
                     input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, a, e, cyc);
    end
  endtask

  task automatic chk_wide(input string nm,
                          input logic [1023:0] a,
                          input logic [1023:0] e,
                          input int ndw);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      for (int i = 0; i < ndw; i++) begin
        if (a[(ndw-1-i)*32 +: 32] !== e[(ndw-1-i)*32 +: 32]) begin
          $display("FAIL %s: DW%0d got %h want %h (cycle %0d)",
                   nm, i, a[(ndw-1-i)*32 +: 32],
                   e[(ndw-1-i)*32 +: 32], cyc);
          break;
        end
      end
    end
  endtask

  // Monitor: every pulse / new output must match the queue head.
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else begin
      chk("in_ready_vs_valid", in_ready, !out_valid);
      if (err_pulse) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL err_pulse: got pulse want none (cycle %0d)",
                   cyc);
        end else begin
          me = q.pop_front();
          chk("err_kind", 1'b1, me.is_err);
          chk("err_cycle", cyc, me.cyc);
        end
      end
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out_valid: got TLP want none (cycle %0d)",
                     cyc);
            cur.is_err = 1'b1;
          end else begin
            cur = q.pop_front();
            chk("out_kind", 1'b0, cur.is_err);
            chk("out_cycle", cyc, cur.cyc);
          end
        end
        if (!cur.is_err) begin
          chk_wide("out_hdr", {896'b0, out_hdr},
                   {896'b0, cur.hdr}, 4);
          chk("out_hdr_4dw", out_hdr_4dw, cur.hdr4);
          chk("out_data_len", out_data_len, cur.len);
          chk_wide("out_data", out_data, cur.data, 32);
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  task automatic push_err(input int acc);
    exp_t e;
    e.is_err = 1'b1;
    e.cyc    = acc + 1;
    e.hdr    = '0;
    e.hdr4   = 1'b0;
    e.data   = '0;
    e.len    = '0;
    q.push_back(e);
  endtask

  // Reference: decide from the whole DW list what must happen.
  task automatic push_model(input logic [31:0] dws[$],
                            input int acc);
    exp_t e;
    int   n;
    int   hlen;
    int   rx;
    int   len;
    bit   hd;
    bit   h4;
    bit   bad;
    n    = dws.size();
    h4   = dws[0][29];
    hd   = dws[0][30];
    len  = int'(dws[0][9:0]);
    hlen = h4 ? 4 : 3;
    rx   = n - hlen;
    bad  = (n > 36) || (n < hlen);
    if (hd) bad = bad || len == 0 || len > 32 || len != rx;
    else    bad = bad || rx != 0;
    if (bad) begin
      push_err(acc);
    end else begin
      e.is_err = 1'b0;
      e.cyc    = acc + 1;
      e.hdr4   = h4;
      e.hdr    = {dws[0], dws[1], dws[2],
                  h4 ? dws[3] : 32'h0};
      e.len    = hd ? 6'(len) : 6'd0;
      e.data   = '0;
      for (int k = 0; k < int'(e.len); k++)
        e.data[1023-32*k -: 32] = dws[hlen+k];
      q.push_back(e);
    end
  endtask

  task automatic send_beat(input logic [255:0] d,
                           input bit sop,
                           input bit eop,
                           input logic [3:0] cnt,
                           output int acc);
    int t;
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    in_data   = d;
    in_valid  = 1'b1;
    in_sop    = sop;
    in_eop    = eop;
    in_dw_cnt = cnt;
    acc = -1;
    t = 0;
    while (acc < 0 && t < 200) begin
      @(posedge clk);
      if (in_ready) acc = cyc;
      t++;
    end
    if (acc < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_accept: got no in_ready want accept");
    end
    #1;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    in_data   = {8{$urandom}};
    in_dw_cnt = 4'($urandom);
  endtask

  // ntrunc>0: send only that many full beats, no eop.
  task automatic send_pkt(input logic [31:0] dws[$],
                          input int ntrunc);
    int n;
    int nb;
    int ns;
    int acc;
    int run;
    bit flag;
    bit last;
    logic [3:0]   cnt;
    logic [255:0] d;
    n    = dws.size();
    nb   = (n + 7) / 8;
    ns   = (ntrunc > 0) ? ntrunc : nb;
    flag = 1'b0;
    acc  = 0;
    for (int b = 0; b < ns; b++) begin
      last = (ntrunc == 0) && (b == nb - 1);
      cnt  = last ? 4'(n - 8*b) : 4'd8;
      for (int i = 0; i < 8; i++)
        d[255-32*i -: 32] = (8*b + i < n) ? dws[8*b+i] : $urandom;
      send_beat(d, b == 0, last, cnt, acc);
      if (b == 0 && abandon) begin
        push_err(acc);
        abandon = 1'b0;
      end
      run = 8*b + int'(cnt);
      if (!flag && run > 36) begin
        flag = 1'b1;
        push_err(acc);
      end
    end
    if (ntrunc > 0) abandon = !flag;
    else if (!flag) push_model(dws, acc);
  endtask

  task automatic gen_pkt(input bit good,
                         output logic [31:0] dws[$]);
    bit h4;
    bit hd;
    int len;
    int rx;
    int hlen;
    h4 = 1'($urandom);
    hd = 1'($urandom);
    if (good || $urandom_range(0, 9) < 7) begin
      len = hd ? $urandom_range(1, 32) : $urandom_range(0, 1023);
      rx  = hd ? len : 0;
    end else begin
      len = $urandom_range(0, 40);
      rx  = $urandom_range(0, 34);
    end
    hlen = h4 ? 4 : 3;
    dws = {};
    dws.push_back({1'($urandom), hd, h4,
                   19'($urandom), 10'(len)});
    for (int i = 1; i < hlen + rx; i++)
      dws.push_back($urandom);
  endtask

  task automatic mk(input logic [31:0] d0, input int n,
                    output logic [31:0] dws[$]);
    dws = {};
    dws.push_back(d0);
    for (int i = 1; i < n; i++) dws.push_back($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || out_valid) && t < 400) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic check_reset();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_err_pulse", err_pulse, 1'b0);
    chk("rst_hdr_4dw", out_hdr_4dw, 1'b0);
    chk("rst_data_len", out_data_len, 6'd0);
    chk_wide("rst_out_hdr", {896'b0, out_hdr}, '0, 4);
    chk_wide("rst_out_data", out_data, '0, 32);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] p[$];
    int          acc;
    int          t;
    bit          need_good;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset();

    // memory read, 3DW, no data
    p = {32'h0000_0001, $urandom, $urandom};
    send_pkt(p, 0);
    // 4DW write, full 32-DW payload over five beats
    mk(32'h6000_0020, 36, p);
    send_pkt(p, 0);
    // 3DW write len 5 in one beat, held 10+ cycles
    drain();
    stall = 1'b1;
    mk(32'h4000_0005, 8, p);
    send_pkt(p, 0);
    repeat (14) @(posedge clk);
    #1;
    stall = 1'b0;
    // length mismatch, then a clean TLP
    mk(32'h4000_0006, 8, p);
    send_pkt(p, 0);
    mk(32'h4000_0002, 5, p);
    send_pkt(p, 0);
    // overflow: six full beats, eop on the sixth
    mk(32'h4000_0020, 48, p);
    send_pkt(p, 0);
    mk(32'h6000_0003, 7, p);
    send_pkt(p, 0);
    // overflow, then sop while dropping
    mk(32'h4000_0020, 48, p);
    send_pkt(p, 6);
    mk(32'h4000_0010, 19, p);
    send_pkt(p, 0);
    // sop during collect abandons the old TLP
    mk(32'h6000_0018, 28, p);
    send_pkt(p, 2);
    mk(32'h4000_0001, 4, p);
    send_pkt(p, 0);
    // bad eop counts
    send_beat({8{$urandom}}, 1'b1, 1'b1, 4'd0, acc);
    push_err(acc);
    mk(32'h4000_0006, 9, p);
    send_beat({p[0], p[1], p[2], p[3], p[4], p[5], p[6], p[7]},
              1'b1, 1'b1, 4'd9, acc);
    push_err(acc);
    // stray non-sop beat in idle is ignored
    send_beat({8{$urandom}}, 1'b0, 1'b1, 4'd4, acc);
    drain();

    need_good = 1'b0;
    for (int it = 0; it < 250; it++) begin
      t = $urandom_range(0, 9);
      if (!need_good && !abandon && t == 0) begin
        send_beat({8{$urandom}}, 1'b0, 1'($urandom),
                  4'($urandom_range(1, 8)), acc);
      end else if (!need_good && t == 1) begin
        if ($urandom_range(0, 3) == 0) begin
          mk(32'h4000_0020, 48, p);
          send_pkt(p, $urandom_range(5, 6));
        end else begin
          mk({2'b01, 1'($urandom), 29'($urandom_range(6, 30))},
             $urandom_range(9, 36), p);
          send_pkt(p, $urandom_range(1, (p.size() - 1) / 8));
        end
        need_good = 1'b1;
      end else begin
        gen_pkt(need_good, p);
        send_pkt(p, 0);
        need_good = 1'b0;
      end
    end
    drain();

    // reset mid-TLP
    mk(32'h6000_0010, 20, p);
    send_pkt(p, 2);
    rst = 1'b1;
    abandon = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset();
    // reset while holding an output
    stall = 1'b1;
    mk(32'h4000_0004, 7, p);
    send_pkt(p, 0);
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    stall = 1'b0;
    chk("hold_queue_empty", 64'(q.size()), 64'd0);
    check_reset();
    mk(32'h0000_0000, 3, p);
    send_pkt(p, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tlp_reassembly.md
Name: tlp_reassembly

Overview:
- RX-side counterpart of the TX data fragmentation path.
- Accepts a TLP from the link side as a stream of 8-DW beats marked with start-of-packet (sop) and end-of-packet (eop).
- Reassembles the beats into one header plus an up-to-32-DW payload, checks the length against the header, and presents the whole TLP on a single wide output with a valid/ready handshake.

Parameters:
- DW, 32, bits per double word.
- BEAT_DW, 8, DWs per input beat.
- MAX_DATA_DW, 32, maximum payload in DW.
- HDR_MAX_DW, 4, maximum header size in DW.
- MAX_TLP_DW, HDR_MAX_DW+MAX_DATA_DW (36), assembly capacity in DW.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  BEAT_DW*DW (256)  beat; DW0 occupies bits [255:224].
- in_valid  in  1  beat valid.
- in_sop  in  1  first beat of TLP.
- in_eop  in  1  last beat of TLP.
- in_dw_cnt  in  4  valid DWs in the eop beat (1..8); ignored when eop=0.
- in_ready  out  1  block accepts the beat.
- out_hdr  out  HDR_MAX_DW*DW (128)  header; a 3DW header is left-aligned and DW3=0.
- out_hdr_4dw  out  1  header is 4 DW.
- out_data  out  MAX_DATA_DW*DW (1024)  payload, left-aligned, zero-filled past the length.
- out_data_len  out  6  payload DW count (0..32).
- out_valid  out  1  assembled TLP available.
- out_ready  in  1  consumer takes the TLP.
- err_pulse  out  1  one-cycle pulse when a TLP is dropped.

Behaviour:
- Reset: FSM=IDLE; DW pointer=0; assembly register=0; out_valid=0; err_pulse=0; all out_* data fields=0; in_ready=1.
- Beat transfer: a beat is accepted when in_valid && in_ready.
- in_ready=0 only in HOLD.
- States:
  - IDLE: an accepted beat with sop=0 is discarded silently. An accepted beat with sop=1 is written at pointer 0 and the pointer is set to 8. If eop is also set, the pointer is set to in_dw_cnt and the FSM goes to the FINISH check. Otherwise go to COLLECT.
  - COLLECT:
    - Each accepted beat is written at the pointer.
    - A non-eop beat adds 8 to the pointer; an eop beat adds in_dw_cnt.
    - An accepted sop beat here means the previous TLP is abandoned: pulse err_pulse and restart at pointer 0 with the new beat.
  - FINISH check, same cycle as the eop acceptance:
    - hdr4 = DW0 bit 29 (Fmt[0]); has_data = DW0 bit 30 (Fmt[1]); len = DW0[9:0].
    - hlen = hdr4 ? 4 : 3.
    - Received payload rx = total DW − hlen.
    - Error if any of the following holds: total < hlen; in_dw_cnt==0 or >8; has_data && (len==0 || len>32 || len!=rx); !has_data && rx!=0.
    - On error: err_pulse for 1 cycle, return to IDLE, no output.
    - Otherwise: register outputs and set out_valid the cycle after eop acceptance (latency 1 cycle). State → HOLD.
  - DROP: entered when the pointer plus an incoming count would exceed 36. Pulse err_pulse once on entry. Accepted beats are discarded until eop, then return to IDLE. A sop while in DROP restarts assembly as in COLLECT, with no second pulse.
  - HOLD: out_* fields stable and out_valid=1 until out_ready. On out_valid && out_ready: out_valid→0 next cycle, pointer cleared, state → IDLE; in_ready returns to 1 the same cycle, giving a 1-cycle bubble.
- Arithmetic: pointer is 6 bits; the sum is computed 7 bits wide before the >36 compare, so no wrap.
- Payload extraction: out_data = assembly DWs [hlen .. hlen+len−1] shifted to the top; all lower DWs are 0.
- rst asserted mid-TLP or in HOLD: immediate return to reset values; the partial TLP is discarded with no err_pulse.
- in_valid=0 cycles inside a TLP are allowed; they are gaps and change no state.

Decomposition:
- Shared package rx_frag_package holds:
  - the DW, BEAT_DW, MAX_DATA_DW, HDR_MAX_DW and MAX_TLP_DW constants;
  - the PTR_WIDTH=6 constant;
  - the FSM enum (IDLE, COLLECT, DROP, HOLD);
  - the Fmt bit-position constants (FMT_4DW_BIT=29, FMT_DATA_BIT=30, LEN_MSB=9).
- One sub-module, tlp_hdr_check: combinational. Takes DW0, the total DW count and in_dw_cnt; produces hdr4, hlen, the payload length and the error flag.

Test Plan:
- Memory-read TLP: single beat, sop=eop=1, dw_cnt=3, DW0=0x0000_0001 (3DW, no data) → out_valid 1 cycle later; out_hdr_4dw=0; out_data_len=0; out_data=0.
- MWr 4DW header, len=32: 5 beats (8,8,8,8, then eop with dw_cnt=4) → out_data_len=32; payload = DWs 4..35; out_hdr = DWs 0..3.
- MWr 3DW header, len=5, in one beat with dw_cnt=8 → out_data_len=5; out_data bits [1023:864] = DW3..DW7, remaining bits zero. Hold out_ready=0 for 10 cycles → outputs stable and in_ready=0 throughout.
- Length mismatch: DW0 len=6 but only 5 payload DWs received → err_pulse once, out_valid stays 0, next TLP accepted normally.
- Overflow: 6 full beats without eop → err_pulse on the 5th beat (the pointer would exceed 36), DROP until eop, then a clean TLP passes.
- Protocol errors:
  - sop arriving during COLLECT → err_pulse, and the new TLP is output correctly.
  - rst asserted mid-TLP → all reset values, no err_pulse.
